// File: rtl/rs485_uart_tx.sv
// 8N1 UART transmitter driving an RS485 transceiver, with optional receive-to-transmit
// turnaround and a driver-enable hold time after the stop bit.
module rs485_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TURN_CYCLES  = 4340,
  parameter int DE_HOLD      = 217
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_tx_sig,
  input  logic [7:0] uart_tx_data,
  input  logic       r2t_delay,
  output logic       uart_idle,
  output logic       txd,
  output logic       rs485_de,
  output logic [2:0] busy_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_TURN  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_HOLD  = 3'd5;

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] TURN_LAST = 16'(TURN_CYCLES - 1);
  localparam logic [15:0] HOLD_LAST = 16'((DE_HOLD > 0) ? DE_HOLD - 1 : 0);

  logic [2:0]  state;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;

  assign busy_state = state;

  // Outputs are loaded together with the state they belong to, so every pin is a flop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      uart_idle <= 1'b1;
      txd       <= 1'b1;
      rs485_de  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (uart_tx_sig) begin
            shreg     <= uart_tx_data;
            cnt       <= '0;
            bit_idx   <= '0;
            uart_idle <= 1'b0;
            rs485_de  <= 1'b1;
            if (r2t_delay) begin
              state <= S_TURN;
              txd   <= 1'b1;
            end else begin
              state <= S_START;
              txd   <= 1'b0;
            end
          end
        end
        S_TURN: begin
          if (cnt == TURN_LAST) begin
            cnt   <= '0;
            state <= S_START;
            txd   <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_START: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= S_DATA;
            txd   <= shreg[0];
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            // Bit 7 is the last data bit; the index never advances past it.
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
              txd   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              txd     <= shreg[1];
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (DE_HOLD == 0) begin
              state     <= S_IDLE;
              uart_idle <= 1'b1;
              rs485_de  <= 1'b0;
            end else begin
              state <= S_HOLD;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt       <= '0;
            state     <= S_IDLE;
            uart_idle <= 1'b1;
            rs485_de  <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state     <= S_IDLE;
          cnt       <= '0;
          uart_idle <= 1'b1;
          rs485_de  <= 1'b0;
          txd       <= 1'b1;
        end
      endcase
    end
  end

endmodule
